td4_out_tx: RTL and testbench

Downstream consumer of the TD4 core's 4-bit output port (the C register value). Watches the nibble for changes and queues each new value in a small FIFO. Transmits every queued value as one ASCII hex character on an 8N1 UART TX line. Gives a serial trace of program output without adding any stall path back into the core.

---
 rtl/td4_out_tx_if.sv | 15 +
 rtl/td4_out_tx.sv | 166 ++++++++++++++++
 tb/tb_td4_out_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/td4_out_tx_if.sv
// Bus bundle for td4_out_tx: core-side nibble/strobe in, UART line and status out.
// FSM_STATE mirrors the transmitter state register for checkers and debug.
interface td4_out_tx_if;
    logic [3:0] DIN;
    logic       EN;
    logic       TXD;
    logic       BUSY;
    logic       OVF;
    logic [4:0] LEVEL;
    logic [1:0] FSM_STATE;

    // DIN/EN carry no back-pressure: EN is a one-way sample strobe, the core never waits.
    modport master (output DIN, EN, input TXD, BUSY, OVF, LEVEL, FSM_STATE);
    modport slave  (input DIN, EN, output TXD, BUSY, OVF, LEVEL, FSM_STATE);
endinterface

// File: rtl/td4_out_tx.sv
// TD4 output-port tracer: queues each change of the 4-bit output and sends it as one ASCII hex
// character on an 8N1 UART line. Define TD4_OUT_TX_CRLF_EN to follow every character with CR, LF.
module td4_out_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         CLK,
    input  logic         RSTB,
    td4_out_tx_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          txd;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic [3:0]    held;
    logic          held_valid;
    logic          ovf;
    logic          push_req;
    logic          push;
    logic          pop;
    logic [3:0]    head;

`ifdef TD4_OUT_TX_CRLF_EN
    // 0: next frame comes from the FIFO, 1: CR is due, 2: LF is due
    logic [1:0]    crlf_step;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign push_req = bus.EN && (!held_valid || (bus.DIN != held));
`ifdef TD4_OUT_TX_CRLF_EN
    assign pop      = (state == IDLE) && (crlf_step == 2'd0) && !empty;
`else
    assign pop      = (state == IDLE) && !empty;
`endif
    // A slot freed by a same-edge pop makes room even when the queue is full.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            held       <= 4'h0;
            held_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push) ovf <= 1'b1;
            if (bus.EN) begin
                held       <= bus.DIN;
                held_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.DIN;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            txd     <= 1'b1;
`ifdef TD4_OUT_TX_CRLF_EN
            crlf_step <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    cnt <= '0;
`ifdef TD4_OUT_TX_CRLF_EN
                    if (crlf_step != 2'd0) begin
                        shreg     <= (crlf_step == 2'd1) ? 8'h0D : 8'h0A;
                        crlf_step <= (crlf_step == 2'd1) ? 2'd2 : 2'd0;
                        txd       <= 1'b0;
                        state     <= START;
                    end else if (pop) begin
                        shreg     <= hex_ascii(head);
                        crlf_step <= 2'd1;
                        txd       <= 1'b0;
                        state     <= START;
                    end
`else
                    if (pop) begin
                        shreg <= hex_ascii(head);
                        txd   <= 1'b0;
                        state <= START;
                    end
`endif
                end
                START: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        txd     <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TXD       = txd;
    assign bus.OVF       = ovf;
    assign bus.LEVEL     = 5'(level);
    assign bus.FSM_STATE = state;
`ifdef TD4_OUT_TX_CRLF_EN
    assign bus.BUSY      = (state != IDLE) || !empty || (crlf_step != 2'd0);
`else
    assign bus.BUSY      = (state != IDLE) || !empty;
`endif

endmodule

// File: tb/tb_td4_out_tx.sv
// Bench for td4_out_tx: directed scenarios plus a random soak, every cycle checked against a
// queue/timer model of the tracer, with a UART receiver decoding TXD for byte-level checks.
module tb_td4_out_tx;

  localparam int C  = 4;
  localparam int D  = 4;
`ifdef TD4_OUT_TX_CRLF_EN
  localparam int NB = 3;
`else
  localparam int NB = 1;
`endif
  localparam int L  = 10 * C + 1;

  logic CLK;
  logic RSTB;
  td4_out_tx_if bus();

  td4_out_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .bus  (bus.slave)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int peak_lvl = 0;
  string hexdig = "0123456789ABCDEF";

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  // reference model: pending values, time left in current transmission, bytes on the wire
  int         m_q[$];
  logic [3:0] m_held;
  bit         m_valid;
  bit         m_ovf;
  int         m_left;
  int         m_s;
  logic [7:0] m_bytes[3];
  logic [7:0] m_sent[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_held  = 4'h0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_left  = 0;
    m_s     = 0;
  endtask

  task automatic model_edge(input logic en, input logic [3:0] din);
    if (m_left == 0 && m_q.size() > 0) begin
      int nib;
      nib = m_q.pop_front();
      m_bytes[0] = hexdig.getc(nib);
      m_bytes[1] = 8'h0D;
      m_bytes[2] = 8'h0A;
      for (int i = 0; i < NB; i++) m_sent.push_back(m_bytes[i]);
      m_left = NB * L - 1;
      m_s    = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_s++;
    end
    if (en) begin
      if (!m_valid || din != m_held) begin
        if (m_q.size() < D) m_q.push_back(int'(din));
        else m_ovf = 1'b1;
      end
      m_held  = din;
      m_valid = 1'b1;
    end
  endtask

  function automatic logic m_txd();
    int j, r, k;
    if (m_left == 0) return 1'b1;
    j = m_s / L;
    r = m_s % L;
    if (r >= 10 * C) return 1'b1;
    k = r / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_bytes[j][k-1];
  endfunction

  // UART receiver: samples mid-bit on falling clock edges, aborts on reset
  initial begin
    int   mcnt;
    bit   mon;
    logic [7:0] mbyte;
    mon = 0; mcnt = 0; mbyte = 8'h00;
    forever begin
      @(negedge CLK or negedge RSTB);
      if (!RSTB) begin
        mon = 0;
        mcnt = 0;
      end else if (!mon) begin
        if (bus.TXD === 1'b0) begin
          mon = 1;
          mcnt = 0;
        end
      end else begin
        mcnt++;
        if ((mcnt % C) == C / 2 && mcnt / C >= 1 && mcnt / C <= 8) mbyte[mcnt/C-1] = bus.TXD;
        if (mcnt == 9 * C + C / 2) begin
          if (bus.TXD === 1'b1) rx_q.push_back(mbyte);
          mon = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic check_outputs();
    chk("txd",   32'(bus.TXD),   32'(m_txd()));
    chk("busy",  32'(bus.BUSY),  32'((m_left > 0) || (m_q.size() > 0)));
    chk("level", 32'(bus.LEVEL), 32'(m_q.size()));
    chk("ovf",   32'(bus.OVF),   32'(m_ovf));
    if (bus.BUSY === 1'b1) busy_cnt++;
    if (int'(bus.LEVEL) > peak_lvl) peak_lvl = int'(bus.LEVEL);
  endtask

  task automatic tick(input logic en, input logic [3:0] din);
    bus.EN  = en;
    bus.DIN = din;
    @(posedge CLK);
    model_edge(en, din);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic drain(input logic en);
    int guard;
    guard = 0;
    while ((m_left != 0 || m_q.size() != 0) && guard < 5000) begin
      tick(en, bus.DIN);
      guard++;
    end
    repeat (4) tick(en, bus.DIN);
  endtask

  task automatic pulse_reset(input string tag);
    #2 RSTB = 1'b0;
    model_reset();
    #1;
    chk({tag, "_rst_txd"},   32'(bus.TXD),   32'd1);
    chk({tag, "_rst_busy"},  32'(bus.BUSY),  32'd0);
    chk({tag, "_rst_level"}, 32'(bus.LEVEL), 32'd0);
    chk({tag, "_rst_ovf"},   32'(bus.OVF),   32'd0);
    chk({tag, "_rst_fsm"},   32'(bus.FSM_STATE), 32'd0);
    repeat (2) @(negedge CLK);
    RSTB = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    pulse_reset(tag);
    rx_q.delete();
    exp_q.delete();
    m_sent.delete();
    busy_cnt = 0;
    peak_lvl = 0;
  endtask

  task automatic push_exp(input int nib);
    exp_q.push_back(hexdig.getc(nib));
`ifdef TD4_OUT_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // scoreboard: received bytes against the expected queue
  task automatic compare_rx(input string tag);
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic shuffle(output int v[16]);
    for (int i = 0; i < 16; i++) v[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = v[i]; v[i] = v[j]; v[j] = t;
    end
  endtask

  initial begin
    int v[16];
    RSTB    = 1'b0;
    bus.EN  = 1'b0;
    bus.DIN = 4'h0;
    model_reset();

    // 1: held value produces exactly one frame
    do_reset("t1");
    tick(1'b1, 4'h3);
    chk("t1_level_after_capture", 32'(bus.LEVEL), 32'd1);
    tick(1'b1, 4'h3);
    chk("t1_txd_low_after_pop", 32'(bus.TXD), 32'd0);
    drain(1'b1);
    repeat (60) tick(1'b1, 4'h3);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'(NB * L));
    push_exp(3);
    compare_rx("t1");

    // 2: repeated value is suppressed
    tick(1'b1, 4'hA);
    tick(1'b1, 4'hA);
    tick(1'b1, 4'hF);
    tick(1'b1, 4'h0);
    drain(1'b0);
    chk("t2_ovf", 32'(bus.OVF), 32'd0);
    push_exp(10); push_exp(15); push_exp(0);
    compare_rx("t2");

    // 3: burst of eight distinct values overflows the queue
    do_reset("t3");
    shuffle(v);
    for (int i = 0; i < 8; i++) tick(1'b1, 4'(v[i]));
    chk("t3_ovf", 32'(bus.OVF), 32'd1);
    drain(1'b0);
    chk("t3_peak_level", 32'(peak_lvl), 32'd4);
    for (int i = 0; i < 5; i++) push_exp(v[i]);
    compare_rx("t3");

    // 4: push lands on the pop edge while full
    do_reset("t4");
    shuffle(v);
    for (int i = 0; i < 5; i++) tick(1'b1, 4'(v[i]));
    chk("t4_full", 32'(bus.LEVEL), 32'd4);
    for (int g = 0; g < 2000 && m_left != 0; g++) tick(1'b0, 4'(v[4]));
    tick(1'b1, 4'(v[5]));
    chk("t4_level_kept", 32'(bus.LEVEL), 32'd4);
    chk("t4_ovf_clear", 32'(bus.OVF), 32'd0);
    drain(1'b0);
    for (int i = 0; i < 6; i++) push_exp(v[i]);
    compare_rx("t4");

    // 5: reset during data bit 3 aborts the frame and invalidates the held value
    do_reset("t5");
    shuffle(v);
    for (int i = 0; i < 6; i++) tick(1'b1, 4'(v[i]));
    chk("t5_ovf_set", 32'(bus.OVF), 32'd1);
    for (int g = 0; g < 200 && m_s != 4 * C + 1; g++) tick(1'b0, 4'(v[5]));
    @(negedge CLK);
    pulse_reset("t5_mid");
    chk("t5_aborted_frame", 32'(rx_q.size()), 32'(exp_q.size()));
    rx_q.delete();
    tick(1'b1, 4'(v[5]));
    chk("t5_recapture", 32'(bus.LEVEL), 32'd1);
    drain(1'b0);
    push_exp(v[5]);
    compare_rx("t5");

`ifdef TD4_OUT_TX_CRLF_EN
    // 6: CR/LF trailer keeps BUSY high across all three frames
    do_reset("t6");
    tick(1'b1, 4'h7);
    drain(1'b0);
    chk("t6_busy_cycles", 32'(busy_cnt), 32'(1 + 3 * 40 + 2));
    exp_q.push_back(8'h37); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    compare_rx("t6");
`endif

    // random soak against the model's transmitted byte stream
    do_reset("soak");
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 3)));
    drain(1'b0);
    foreach (m_sent[i]) exp_q.push_back(m_sent[i]);
    compare_rx("soak");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
